sram_fifo_arbiter: RTL and testbench

- Shares the mySRAM FIFO store between two write requesters (A, B) and one read consumer.
- Round-robin burst arbitration on the write side.
- Keeps its own occupancy count so the SRAM is never written when full or read when empty.
- Sits between the requester logic and a mySRAM instance and drives that instance's read/write/data_in.

---
 rtl/sram_fifo_pkg.sv | 19 +
 rtl/sram_fifo_arbiter_occupancy.sv | 41 ++++
 rtl/sram_fifo_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_fifo_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared definitions for the mySRAM FIFO arbiter and its occupancy counter.
package sram_fifo_pkg;

  localparam int DEF_BITS       = 12;
  localparam int DEF_WORD_DEPTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST_A = 2'd1,
    BURST_B = 2'd2
  } grant_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/sram_fifo_arbiter_occupancy.sv
// Word occupancy tracker: counts accepted writes minus accepted reads and
// decodes full/empty from the registered count.
module sram_occupancy_ctr
  import sram_fifo_pkg::*;
#(
  parameter int word_depth = DEF_WORD_DEPTH,
  parameter int addr_width = DEF_ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_accept,
  input  logic                rd_accept,
  output logic [addr_width:0] count,
  output logic                full,
  output logic                empty
);

  logic [addr_width:0] count_q;
  logic [addr_width:0] count_d;

  // Simultaneous write and read leave the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (addr_width+1)'(1);
      2'b01:   count_d = count_q - (addr_width+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign full  = (count_q == (addr_width+1)'(word_depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/sram_fifo_arbiter.sv
// Two-requester round-robin burst write arbiter and single-consumer read
// pipeline in front of a mySRAM FIFO store.
module sram_fifo_arbiter
  import sram_fifo_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int word_depth = DEF_WORD_DEPTH,
  parameter int addr_width = DEF_ADDR_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_a,
  input  logic [BITS-1:0]     data_a,
  output logic                ack_a,
  input  logic                req_b,
  input  logic [BITS-1:0]     data_b,
  output logic                ack_b,
  input  logic                rd_req,
  output logic [BITS-1:0]     rd_data,
  output logic                rd_valid,
  output logic                sram_write,
  output logic                sram_read,
  output logic [BITS-1:0]     sram_data_in,
  input  logic [BITS-1:0]     sram_data_out,
  input  logic                sram_ready,
  input  logic                sram_overflow,
  output logic [addr_width:0] count,
  output logic                full,
  output logic                empty,
  output logic                err_overflow
);

  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  grant_state_e      state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  req_id_e           last_grant_q, last_grant_d;

  logic              sram_write_q, sram_write_d;
  logic              sram_read_q, sram_read_d;
  logic [BITS-1:0]   sram_data_in_q, sram_data_in_d;
  logic              rd_valid_q, rd_valid_d;
  logic [BITS-1:0]   rd_data_q, rd_data_d;
  logic              err_overflow_q, err_overflow_d;

  logic              wr_accept;
  logic              rd_accept;
  logic              burst_last;

  // A stall on full or !sram_ready keeps the grant but blocks the accept.
  assign ack_a      = (state_q == BURST_A) && req_a && !full && sram_ready;
  assign ack_b      = (state_q == BURST_B) && req_b && !full && sram_ready;
  assign wr_accept  = ack_a || ack_b;
  assign rd_accept  = rd_req && !empty && sram_ready;
  assign burst_last = (beat_q == BEAT_W'(MAX_BURST - 1));

  sram_occupancy_ctr #(
    .word_depth (word_depth),
    .addr_width (addr_width)
  ) u_occupancy (
    .clk       (clk),
    .rst       (rst),
    .wr_accept (wr_accept),
    .rd_accept (rd_accept),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Grant selection: rotate away from last_grant on a tie, end a burst after
  // MAX_BURST beats or when the owner drops its request.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) state_d = (last_grant_q == REQ_A) ? BURST_B : BURST_A;
        else if (req_a)     state_d = BURST_A;
        else if (req_b)     state_d = BURST_B;
      end
      BURST_A: begin
        if ((ack_a && burst_last) || !req_a) begin
          beat_d       = '0;
          last_grant_d = REQ_A;
          state_d      = req_b ? BURST_B : (req_a ? BURST_A : IDLE);
        end else if (ack_a) begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      BURST_B: begin
        if ((ack_b && burst_last) || !req_b) begin
          beat_d       = '0;
          last_grant_d = REQ_B;
          state_d      = req_a ? BURST_A : (req_b ? BURST_B : IDLE);
        end else if (ack_b) begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // SRAM strobes, read return pipeline and sticky overflow flag.
  always_comb begin
    sram_write_d   = wr_accept;
    sram_data_in_d = sram_data_in_q;
    if (ack_a)      sram_data_in_d = data_a;
    else if (ack_b) sram_data_in_d = data_b;
    sram_read_d    = rd_accept;
    rd_valid_d     = sram_read_q;
    rd_data_d      = sram_read_q ? sram_data_out : rd_data_q;
    err_overflow_d = err_overflow_q || sram_overflow;
  end

  // All arbiter state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      last_grant_q   <= REQ_B;
      sram_write_q   <= 1'b0;
      sram_read_q    <= 1'b0;
      sram_data_in_q <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      last_grant_q   <= last_grant_d;
      sram_write_q   <= sram_write_d;
      sram_read_q    <= sram_read_d;
      sram_data_in_q <= sram_data_in_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign sram_write   = sram_write_q;
  assign sram_read    = sram_read_q;
  assign sram_data_in = sram_data_in_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_sram_fifo_arbiter.sv
// Self-checking bench for sram_fifo_arbiter with a behavioural FIFO-ordered
// SRAM and a queue-based scoreboard of written and read words.
module tb_sram_fifo_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, rd_req;
  logic [11:0] data_a, data_b;
  logic        ack_a, ack_b;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        sram_write, sram_read;
  logic [11:0] sram_data_in;
  logic [11:0] sram_data_out;
  logic        sram_ready, sram_overflow;
  logic [3:0]  count;
  logic        full, empty, err_overflow;

  int checks   = 0;
  int failures = 0;

  logic got_a, got_b, got_v;

  // scoreboard state
  logic [11:0] wr_q[$];
  logic [11:0] content_q[$];
  logic [11:0] rd_q[$];
  int          exp_count;
  logic        wr_exp, sr_exp, rv_exp, exp_err;

  // behavioural SRAM
  logic [11:0] mem [0:7];
  logic [2:0]  wr_ptr, rd_ptr;

  sram_fifo_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_a         (req_a),
    .data_a        (data_a),
    .ack_a         (ack_a),
    .req_b         (req_b),
    .data_b        (data_b),
    .ack_b         (ack_b),
    .rd_req        (rd_req),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .sram_write    (sram_write),
    .sram_read     (sram_read),
    .sram_data_in  (sram_data_in),
    .sram_data_out (sram_data_out),
    .sram_ready    (sram_ready),
    .sram_overflow (sram_overflow),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  // SRAM pointers advance on each strobe, giving FIFO order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (sram_write) wr_ptr <= wr_ptr + 3'd1;
      if (sram_read)  rd_ptr <= rd_ptr + 3'd1;
    end
  end

  // SRAM storage array.
  always_ff @(posedge clk) begin
    if (!rst && sram_write) mem[wr_ptr] <= sram_data_in;
  end

  assign sram_data_out = mem[rd_ptr];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic [11:0] da, input logic rb,
                               input logic [11:0] db, input logic rr, input logic rdy,
                               input logic ovf);
    req_a         = ra;
    data_a        = da;
    req_b         = rb;
    data_b        = db;
    rd_req        = rr;
    sram_ready    = rdy;
    sram_overflow = ovf;
    @(negedge clk);
    got_a = ack_a;
    got_b = ack_b;
    got_v = rd_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    req_a = 0; req_b = 0; rd_req = 0; sram_ready = 1; sram_overflow = 0;
    data_a = '0; data_b = '0;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor sampling on the falling edge.
  initial begin
    logic        wr_acc, rd_acc;
    logic [11:0] d;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_q.delete(); content_q.delete(); rd_q.delete();
        exp_count = 0; wr_exp = 0; sr_exp = 0; rv_exp = 0; exp_err = 0;
      end else begin
        checkOutput("sram_write", sram_write, wr_exp);
        if (wr_exp) begin
          if (wr_q.size() == 0) checkOutput("wr_q_underflow", 1, 0);
          else checkOutput("sram_data_in", sram_data_in, wr_q.pop_front());
        end
        checkOutput("sram_read", sram_read, sr_exp);
        checkOutput("rd_valid", rd_valid, rv_exp);
        if (rv_exp) begin
          if (rd_q.size() == 0) checkOutput("rd_q_underflow", 1, 0);
          else checkOutput("rd_data", rd_data, rd_q.pop_front());
        end
        checkOutput("count", count, exp_count);
        checkOutput("full", full, exp_count == 8);
        checkOutput("empty", empty, exp_count == 0);
        checkOutput("err_overflow", err_overflow, exp_err);
        checkOutput("count_le_depth", count <= 4'd8, 1);
        checkOutput("ack_exclusive", ack_a & ack_b, 0);
        if (exp_count == 8 || !sram_ready) begin
          checkOutput("ack_a_blocked", ack_a, 0);
          checkOutput("ack_b_blocked", ack_b, 0);
        end
        wr_acc = ack_a | ack_b;
        rd_acc = rd_req && exp_count != 0 && sram_ready;
        if (rd_acc && content_q.size() > 0) rd_q.push_back(content_q.pop_front());
        if (wr_acc) begin
          d = ack_a ? data_a : data_b;
          wr_q.push_back(d);
          content_q.push_back(d);
        end
        exp_count = exp_count + int'(wr_acc) - int'(rd_acc);
        rv_exp  = sr_exp;
        sr_exp  = rd_acc;
        wr_exp  = wr_acc;
        exp_err = exp_err | sram_overflow;
      end
    end
  end

  initial begin
    logic [11:0] nxt;
    logic [11:0] pat_a, pat_b;

    rst = 1'b1;
    req_a = 0; req_b = 0; rd_req = 0; sram_ready = 1; sram_overflow = 0;
    data_a = '0; data_b = '0;
    #1;
    checkOutput("rst_ack_a", ack_a, 0);
    checkOutput("rst_ack_b", ack_b, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_sram_write", sram_write, 0);
    checkOutput("rst_err", err_overflow, 0);
    applyReset();

    // single requester A, 6 accepts across a burst rotation
    nxt = 12'h001;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, nxt, 0, '0, 0, 1, 0);
      checkOutput("t1_ack_a", got_a, (i == 0) ? 0 : 1);
      if (got_a) nxt = nxt + 12'h001;
    end
    applyStimulus(0, '0, 0, '0, 0, 1, 0);
    checkOutput("t1_count", count, 6);

    // both requesters, 4 beats each until full
    applyReset();
    pat_a = 12'b0000_0001_1110;
    pat_b = 12'b0001_1110_0000;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 12'hA00 + 12'(i), 1, 12'hB00 + 12'(i), 0, 1, 0);
      checkOutput("t2_ack_a", got_a, pat_a[i]);
      checkOutput("t2_ack_b", got_b, pat_b[i]);
    end
    checkOutput("t2_count", count, 8);
    checkOutput("t2_full", full, 1);

    // drain three words from a full store
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, '0, 1, 1, 0);
    checkOutput("t3_count", count, 5);
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, '0, 0, 1, 0);

    // concurrent write and read at count 4
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 12'h400 + 12'(i), 0, '0, 0, 1, 0);
    checkOutput("t4_fill", count, 4);
    for (int j = 0; j < 6; j++) begin
      applyStimulus(1, 12'h410 + 12'(j), 0, '0, 1, 1, 0);
      checkOutput("t4_ack_a", got_a, 1);
      checkOutput("t4_rd_valid", got_v, (j >= 2) ? 1 : 0);
      checkOutput("t4_count", count, 4);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, '0, 0, '0, 0, 1, 0);
      checkOutput("t4_drain_valid", got_v, (k < 2) ? 1 : 0);
    end

    // sram_ready stall holds grant and count
    applyStimulus(1, 12'h501, 1, 12'h601, 0, 1, 0);
    checkOutput("t5_idle_ack", got_a | got_b, 0);
    applyStimulus(1, 12'h502, 1, 12'h602, 0, 1, 0);
    checkOutput("t5_pre_ack_b", got_b, 1);
    checkOutput("t5_pre_ack_a", got_a, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 12'h503, 1, 12'h603, 1, 0, 0);
      checkOutput("t5_stall_ack", got_a | got_b, 0);
      checkOutput("t5_stall_count", count, 5);
    end
    applyStimulus(1, 12'h504, 1, 12'h604, 0, 1, 0);
    checkOutput("t5_post_ack_b", got_b, 1);
    checkOutput("t5_post_ack_a", got_a, 0);
    checkOutput("t5_post_count", count, 6);
    applyStimulus(0, '0, 0, '0, 0, 1, 0);

    // overflow flag is sticky
    applyStimulus(0, '0, 0, '0, 0, 1, 1);
    checkOutput("t6_err_set", err_overflow, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, '0, 0, '0, 0, 1, 0);
      checkOutput("t6_err_hold", err_overflow, 1);
    end

    // reset while a read is in flight
    applyStimulus(0, '0, 0, '0, 1, 1, 0);
    checkOutput("t7_sram_read", sram_read, 1);
    rd_req = 0;
    rst = 1'b1;
    #1;
    checkOutput("t7_sram_read_rst", sram_read, 0);
    checkOutput("t7_count_rst", count, 0);
    checkOutput("t7_empty_rst", empty, 1);
    checkOutput("t7_err_rst", err_overflow, 0);
    checkOutput("t7_rd_data_rst", rd_data, 0);
    checkOutput("t7_data_in_rst", sram_data_in, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, '0, 0, '0, 0, 1, 0);
      checkOutput("t7_no_valid", got_v, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
